csr_trap_unit: RTL and testbench

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

---
 rtl/csr_trap_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with cycle/instret counters, interrupt arbitration and trap/mret redirect.
// Define CSR_VECTORED_EN to enable vectored mtvec mode (mtvec[1:0] = 01).
module csr_trap_unit #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [11:0]     rd_addr,
    output logic [XLEN-1:0] rd_data,
    input  logic            wr_valid,
    input  logic [11:0]     wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            retire,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MCNTINH  = 12'h320;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    localparam logic [XLEN-1:0] IRQ_MASK    = XLEN'(12'h888);
    localparam logic [XLEN-1:0] CNTINH_MASK = XLEN'(3'b101);
    localparam logic [XLEN-1:0] ALIGN4_MASK = ~(XLEN'(2'b11));
`ifdef CSR_VECTORED_EN
    localparam logic [XLEN-1:0] TVEC_MASK   = '1;
`else
    localparam logic [XLEN-1:0] TVEC_MASK   = ALIGN4_MASK;
`endif

    logic            r_mst_mie;
    logic            r_mst_mpie;
    logic [1:0]      r_mst_mpp;
    logic [1:0]      r_mst_fs;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mip;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mcycle;
    logic [XLEN-1:0] r_minstret;
    logic [XLEN-1:0] r_mcntinh;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_take_trap;
    logic            w_take_mret;
    logic            w_take_wr;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mip_next;
    logic [XLEN-1:0] w_irq_pend;
    logic [XLEN-1:0] w_tvec_base;
    logic [XLEN-1:0] w_trap_target;

    // Trap beats mret beats CSR write; the losers are discarded outright.
    assign w_take_trap = trap_valid;
    assign w_take_mret = mret_valid & ~trap_valid;
    assign w_take_wr   = wr_valid & ~trap_valid & ~mret_valid;

    always_comb begin
        w_mstatus           = '0;
        w_mstatus[3]        = r_mst_mie;
        w_mstatus[7]        = r_mst_mpie;
        w_mstatus[12:11]    = r_mst_mpp;
        w_mstatus[14:13]    = r_mst_fs;
        w_mstatus[XLEN-1]   = |r_mst_fs;
    end

    always_comb begin
        w_mip_next     = '0;
        w_mip_next[11] = irq_ext;
        w_mip_next[7]  = irq_timer;
        w_mip_next[3]  = irq_sw;
    end

    assign w_irq_pend = r_mip & r_mie;
    assign irq_req    = r_mst_mie & (|w_irq_pend);

    always_comb begin
        irq_cause = '0;
        if (irq_req) begin
            if (w_irq_pend[11])
                irq_cause = {1'b1, (XLEN-1)'(11)};
            else if (w_irq_pend[3])
                irq_cause = {1'b1, (XLEN-1)'(3)};
            else
                irq_cause = {1'b1, (XLEN-1)'(7)};
        end
    end

    assign w_tvec_base = r_mtvec & ALIGN4_MASK;

`ifdef CSR_VECTORED_EN
    always_comb begin
        w_trap_target = w_tvec_base;
        if (r_mtvec[1:0] == 2'b01 && trap_cause[XLEN-1])
            w_trap_target = w_tvec_base + {trap_cause[XLEN-3:0], 2'b00};
    end
`else
    assign w_trap_target = w_tvec_base;
`endif

    always_comb begin
        unique case (rd_addr)
            A_MSTATUS:  rd_data = w_mstatus;
            A_MIE:      rd_data = r_mie;
            A_MIP:      rd_data = r_mip;
            A_MTVEC:    rd_data = r_mtvec;
            A_MSCRATCH: rd_data = r_mscratch;
            A_MEPC:     rd_data = r_mepc;
            A_MCAUSE:   rd_data = r_mcause;
            A_MTVAL:    rd_data = r_mtval;
            A_MCYCLE:   rd_data = r_mcycle;
            A_MINSTRET: rd_data = r_minstret;
            A_MCNTINH:  rd_data = r_mcntinh;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mst_mie  <= 1'b0;
            r_mst_mpie <= 1'b0;
            r_mst_mpp  <= 2'b00;
            r_mst_fs   <= 2'b00;
            r_mie      <= '0;
            r_mip      <= '0;
            r_mtvec    <= RESET_MTVEC & TVEC_MASK;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_mcntinh  <= '0;
        end else begin
            r_mip <= w_mip_next;
            if (w_take_trap) begin
                r_mepc     <= trap_pc & ALIGN4_MASK;
                r_mcause   <= trap_cause;
                r_mtval    <= trap_tval;
                r_mst_mpie <= r_mst_mie;
                r_mst_mie  <= 1'b0;
                r_mst_mpp  <= 2'b11;
            end else if (w_take_mret) begin
                r_mst_mie  <= r_mst_mpie;
                r_mst_mpie <= 1'b1;
                r_mst_mpp  <= 2'b00;
            end else if (w_take_wr) begin
                case (wr_addr)
                    A_MSTATUS: begin
                        r_mst_mie  <= wr_data[3];
                        r_mst_mpie <= wr_data[7];
                        r_mst_mpp  <= wr_data[12:11];
                        r_mst_fs   <= wr_data[14:13];
                    end
                    A_MIE:      r_mie      <= wr_data & IRQ_MASK;
                    A_MTVEC:    r_mtvec    <= wr_data & TVEC_MASK;
                    A_MSCRATCH: r_mscratch <= wr_data;
                    A_MEPC:     r_mepc     <= wr_data;
                    A_MCAUSE:   r_mcause   <= wr_data;
                    A_MTVAL:    r_mtval    <= wr_data;
                    A_MCNTINH:  r_mcntinh  <= wr_data & CNTINH_MASK;
                    default: ;
                endcase
            end
        end
    end

    // A CSR write to a counter takes precedence over that cycle's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_take_wr && wr_addr == A_MCYCLE)
                r_mcycle <= wr_data;
            else if (!r_mcntinh[0])
                r_mcycle <= r_mcycle + XLEN'(1);

            if (w_take_wr && wr_addr == A_MINSTRET)
                r_minstret <= wr_data;
            else if (retire && !r_mcntinh[2])
                r_minstret <= r_minstret + XLEN'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_take_trap | w_take_mret;
            if (w_take_trap)
                r_redirect_pc <= w_trap_target;
            else if (w_take_mret)
                r_redirect_pc <= r_mepc;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: CSR vector table plus trap/mret/interrupt/counter/reset sequences.
module tb_csr_trap_unit;
    localparam int          XLEN     = 64;
    localparam logic [63:0] RST_TVEC = 64'h8000_0100;
    localparam logic [63:0] ONES     = '1;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MCNTINH  = 12'h320;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

`ifdef CSR_VECTORED_EN
    localparam logic [63:0] EXP_TVEC_203 = 64'h203;
`else
    localparam logic [63:0] EXP_TVEC_203 = 64'h200;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [11:0]     rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            wr_valid;
    logic [11:0]     wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            trap_valid;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_tval;
    logic            mret_valid;
    logic            retire;
    logic            irq_ext;
    logic            irq_timer;
    logic            irq_sw;
    logic            irq_req;
    logic [XLEN-1:0] irq_cause;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    always #5 clk = ~clk;

    csr_trap_unit #(.XLEN(XLEN), .RESET_MTVEC(RST_TVEC)) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_valid(mret_valid), .retire(retire),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
        .irq_req(irq_req), .irq_cause(irq_cause),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic        we;
        logic [11:0] wa;
        logic [63:0] wd;
        logic [11:0] ra;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[17];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [63:0] exp);
        rd_addr = a;
        #1;
        check(name, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw_redirect;
        tbl[0]  = '{1'b1, A_MSCRATCH, 64'h1234_5678_9ABC_DEF0, A_MSCRATCH, 64'h1234_5678_9ABC_DEF0};
        tbl[1]  = '{1'b1, A_MIP,      64'h888,                 A_MIP,      64'h0};
        tbl[2]  = '{1'b1, 12'h7C0,    64'hFFFF,                12'h7C0,    64'h0};
        tbl[3]  = '{1'b1, A_MSTATUS,  64'h6000,                A_MSTATUS,  64'h8000_0000_0000_6000};
        tbl[4]  = '{1'b1, A_MSTATUS,  64'h8000_0000_0000_0000, A_MSTATUS,  64'h0};
        tbl[5]  = '{1'b1, A_MSTATUS,  ONES,                    A_MSTATUS,  64'h8000_0000_0000_7888};
        tbl[6]  = '{1'b1, A_MSTATUS,  64'h0,                   A_MSTATUS,  64'h0};
        tbl[7]  = '{1'b1, A_MTVEC,    64'h203,                 A_MTVEC,    EXP_TVEC_203};
        tbl[8]  = '{1'b1, A_MIE,      64'hFFFF,                A_MIE,      64'h888};
        tbl[9]  = '{1'b1, A_MIE,      64'h0,                   A_MIE,      64'h0};
        tbl[10] = '{1'b1, A_MCNTINH,  64'hF,                   A_MCNTINH,  64'h5};
        tbl[11] = '{1'b1, A_MCNTINH,  64'h0,                   A_MCNTINH,  64'h0};
        tbl[12] = '{1'b1, A_MEPC,     64'h1000,                A_MEPC,     64'h1000};
        tbl[13] = '{1'b1, A_MCAUSE,   64'h8000_0000_0000_0007, A_MCAUSE,   64'h8000_0000_0000_0007};
        tbl[14] = '{1'b1, A_MTVAL,    64'hABCD,                A_MTVAL,    64'hABCD};
        tbl[15] = '{1'b0, 12'h000,    64'h0,                   12'hF14,    64'h0};
        tbl[16] = '{1'b0, 12'h000,    64'h0,                   A_MSCRATCH, 64'h1234_5678_9ABC_DEF0};

        reset = 1'b0;
        rd_addr = A_MTVEC; wr_valid = 0; wr_addr = 0; wr_data = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
        mret_valid = 0; retire = 0; irq_ext = 1'b1; irq_timer = 0; irq_sw = 0;

        // Reset state, with an interrupt line high that must not reach mip.
        repeat (3) cyc();
        rd_chk("rst_mtvec", A_MTVEC, RST_TVEC);
        rd_chk("rst_mstatus", A_MSTATUS, 64'h0);
        rd_chk("rst_mcycle", A_MCYCLE, 64'h0);
        rd_chk("rst_mip", A_MIP, 64'h0);
        check("rst_redirect_valid", {63'h0, redirect_valid}, 64'h0);
        check("rst_redirect_pc", redirect_pc, 64'h0);
        check("rst_irq_req", {63'h0, irq_req}, 64'h0);
        irq_ext = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        saw_redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (redirect_valid) saw_redirect = 1'b1;
        end
        rd_chk("idle_mtvec", A_MTVEC, RST_TVEC);
        rd_addr = A_MCYCLE;
        #1;
        check("idle_mcycle_9to11", {63'h0, (rd_data >= 64'd9 && rd_data <= 64'd11)}, 64'h1);
        check("idle_no_redirect", {63'h0, saw_redirect}, 64'h0);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].we) csr_wr(tbl[i].wa, tbl[i].wd);
            else cyc();
            rd_chk($sformatf("vec%0d", i), tbl[i].ra, tbl[i].exp);
        end

        // Read reflects registered state only.
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = A_MSCRATCH; wr_data = 64'h77;
        rd_chk("no_bypass_old", A_MSCRATCH, 64'h1234_5678_9ABC_DEF0);
        cyc();
        wr_valid = 1'b0;
        rd_chk("no_bypass_new", A_MSCRATCH, 64'h77);

        // Trap then mret.
        csr_wr(A_MTVEC, 64'h200);
        csr_wr(A_MSTATUS, 64'h8);
        trap_valid = 1'b1; trap_cause = 64'd2; trap_pc = 64'h1006; trap_tval = 64'h55;
        cyc();
        trap_valid = 1'b0;
        check("trap_redirect_valid", {63'h0, redirect_valid}, 64'h1);
        check("trap_redirect_pc", redirect_pc, 64'h200);
        rd_chk("trap_mepc", A_MEPC, 64'h1004);
        rd_chk("trap_mstatus", A_MSTATUS, 64'h1880);
        rd_chk("trap_mcause", A_MCAUSE, 64'h2);
        rd_chk("trap_mtval", A_MTVAL, 64'h55);
        cyc();
        check("trap_pulse_end", {63'h0, redirect_valid}, 64'h0);

        mret_valid = 1'b1;
        cyc();
        mret_valid = 1'b0;
        check("mret_redirect_valid", {63'h0, redirect_valid}, 64'h1);
        check("mret_redirect_pc", redirect_pc, 64'h1004);
        rd_chk("mret_mstatus", A_MSTATUS, 64'h88);
        cyc();
        check("mret_pulse_end", {63'h0, redirect_valid}, 64'h0);

        // Same-cycle trap, mret and write: only the trap lands.
        trap_valid = 1'b1; trap_cause = 64'd7; trap_pc = 64'h2002; trap_tval = 64'h0;
        mret_valid = 1'b1;
        wr_valid = 1'b1; wr_addr = A_MSCRATCH; wr_data = 64'h5;
        cyc();
        trap_valid = 1'b0; mret_valid = 1'b0; wr_valid = 1'b0;
        check("prio_redirect_pc", redirect_pc, 64'h200);
        rd_chk("prio_mscratch", A_MSCRATCH, 64'h77);
        rd_chk("prio_mcause", A_MCAUSE, 64'h7);
        rd_chk("prio_mepc", A_MEPC, 64'h2000);
        rd_chk("prio_mstatus", A_MSTATUS, 64'h1880);

        mret_valid = 1'b1;
        wr_valid = 1'b1; wr_addr = A_MSCRATCH; wr_data = 64'h9;
        cyc();
        mret_valid = 1'b0; wr_valid = 1'b0;
        check("prio2_redirect_pc", redirect_pc, 64'h2000);
        rd_chk("prio2_mscratch", A_MSCRATCH, 64'h77);
        rd_chk("prio2_mstatus", A_MSTATUS, 64'h88);

        // Interrupt arbitration.
        csr_wr(A_MIE, 64'h888);
        csr_wr(A_MSTATUS, 64'h8);
        irq_timer = 1'b1; irq_ext = 1'b1;
        #1;
        check("irq_latency_not_yet", {63'h0, irq_req}, 64'h0);
        cyc();
        check("irq_req_ext_tmr", {63'h0, irq_req}, 64'h1);
        check("irq_cause_ext_tmr", irq_cause, 64'h8000_0000_0000_000B);
        rd_chk("irq_mip", A_MIP, 64'h880);
        irq_sw = 1'b1;
        cyc();
        check("irq_cause_all", irq_cause, 64'h8000_0000_0000_000B);
        irq_ext = 1'b0;
        cyc();
        check("irq_cause_sw_tmr", irq_cause, 64'h8000_0000_0000_0003);
        irq_sw = 1'b0;
        cyc();
        check("irq_cause_tmr", irq_cause, 64'h8000_0000_0000_0007);
        csr_wr(A_MSTATUS, 64'h0);
        check("irq_gated_by_mie", {63'h0, irq_req}, 64'h0);
        irq_timer = 1'b0;

        // Counters: wrap, inhibit, write-over-increment.
        csr_wr(A_MCYCLE, ONES);
        rd_chk("mcycle_written", A_MCYCLE, ONES);
        cyc();
        rd_chk("mcycle_wrap", A_MCYCLE, 64'h0);
        csr_wr(A_MCYCLE, 64'h0);
        repeat (5) cyc();
        rd_chk("mcycle_count5", A_MCYCLE, 64'h5);
        csr_wr(A_MCNTINH, 64'h1);
        csr_wr(A_MCYCLE, 64'h55);
        repeat (3) cyc();
        rd_chk("mcycle_inhibit", A_MCYCLE, 64'h55);

        csr_wr(A_MINSTRET, 64'd10);
        retire = 1'b1;
        repeat (3) cyc();
        retire = 1'b0;
        rd_chk("minstret_count", A_MINSTRET, 64'd13);
        retire = 1'b1;
        csr_wr(A_MINSTRET, 64'd100);
        retire = 1'b0;
        rd_chk("minstret_wr_override", A_MINSTRET, 64'd100);
        csr_wr(A_MCNTINH, 64'h4);
        retire = 1'b1;
        repeat (2) cyc();
        retire = 1'b0;
        rd_chk("minstret_inhibit", A_MINSTRET, 64'd100);
        csr_wr(A_MCNTINH, 64'h0);
        csr_wr(A_MINSTRET, ONES);
        retire = 1'b1;
        cyc();
        retire = 1'b0;
        rd_chk("minstret_wrap", A_MINSTRET, 64'h0);

        // Reset landing while a redirect is outstanding.
        trap_valid = 1'b1; trap_cause = 64'd1; trap_pc = 64'h3000;
        @(posedge clk);
        #2;
        reset = 1'b0;
        trap_valid = 1'b0;
        #1;
        check("rst_mid_redirect_valid", {63'h0, redirect_valid}, 64'h0);
        check("rst_mid_redirect_pc", redirect_pc, 64'h0);
        rd_chk("rst_mid_mtvec", A_MTVEC, RST_TVEC);
        rd_chk("rst_mid_mepc", A_MEPC, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        check("rst_mid_after", {63'h0, redirect_valid}, 64'h0);

        // Reset asserted before the trap edge: the trap is never taken.
        trap_valid = 1'b1; trap_pc = 64'h4000;
        #1;
        reset = 1'b0;
        cyc();
        trap_valid = 1'b0;
        reset = 1'b1;
        cyc();
        check("rst_pre_edge_redirect", {63'h0, redirect_valid}, 64'h0);
        rd_chk("rst_pre_edge_mepc", A_MEPC, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
